// File: rtl/quiz_round_arbiter.sv
// quiz_round_arbiter: per-question sequencer and buzz arbiter for the 4-player quiz.
// Outcomes are packed as 2-bit codes into per-player result lists, one slot per question.
// Optional feature macro: ROUND_ROBIN_EN selects rotating buzz priority (default: fixed,
// player1 highest).
//
//   state  | meaning
//   IDLE   | waiting for host to open a question
//   READY  | question being read; any press is a foul
//   ARMED  | buzzers armed, buzz window counting down
//   LOCKED | one player locked in, answer window counting down
//   COMMIT | one cycle: write result slot, advance play_count
//   DONE   | game over, frozen until rst
module quiz_round_arbiter #(
  parameter int MAX_Q         = 9,
  parameter int TICKS_PER_SEC = 100000000,
  parameter int BUZZ_TIME     = 5,
  parameter int ANSWER_TIME   = 10,
  parameter int BUZZ_CYCLES   = 20000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         btn_edge,
  input  logic               host_start,
  input  logic               host_correct,
  input  logic               host_wrong,
  input  logic               host_skip,
  output logic [3:0]         play_count,
  output logic [2*MAX_Q-1:0] player1_list,
  output logic [2*MAX_Q-1:0] player2_list,
  output logic [2*MAX_Q-1:0] player3_list,
  output logic [2*MAX_Q-1:0] player4_list,
  output logic [3:0]         winner,
  output logic [2:0]         state,
  output logic [3:0]         time_left,
  output logic               buzzer
);

  localparam int LW = 2 * MAX_Q;
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX    = TW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BUZZ_LOAD   = BW'(BUZZ_CYCLES);
  localparam logic [3:0]    MAX_Q_C     = 4'(MAX_Q);
  localparam logic [3:0]    BUZZ_TIME_C = 4'(BUZZ_TIME);
  localparam logic [3:0]    ANS_TIME_C  = 4'(ANSWER_TIME);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_ARMED  = 3'd2,
    S_LOCKED = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      play_q, play_d;
  logic [LW-1:0]   list_q [4];
  logic [LW-1:0]   list_d [4];
  logic [3:0]      winner_q, winner_d;
  logic [3:0]      time_q, time_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      code_q, code_d;
  logic [BW-1:0]   buzz_q;
  logic            buzz_load;
  logic [1:0]      search_base;
  logic [3:0]      grant;
  logic            tick_wrap;

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] win_idx;

  // index of the current winner, used to move the priority pointer past it
  always_comb begin
    win_idx = 2'd0;
    for (int p = 0; p < 4; p++)
      if (winner_q[p]) win_idx = 2'(p);
  end

  // priority pointer advances only when a real winner is committed
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= 2'd0;
    else if (state_q == S_COMMIT && winner_q != 4'd0) rr_ptr_q <= win_idx + 2'd1;
  end

  assign search_base = rr_ptr_q;
`else
  assign search_base = 2'd0;
`endif

  // first pressed player found scanning upward from search_base
  always_comb begin
    logic [1:0] idx;
    idx   = 2'd0;
    grant = 4'd0;
    for (int i = 0; i < 4; i++) begin
      idx = search_base + 2'(i);
      if (grant == 4'd0 && btn_edge[idx]) grant[idx] = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state and datapath next values; skip outranks every other event
  always_comb begin
    state_d   = state_q;
    play_d    = play_q;
    list_d    = list_q;
    winner_d  = winner_q;
    time_d    = time_q;
    tick_d    = tick_q;
    code_d    = code_q;
    buzz_load = 1'b0;
    tick_wrap = (tick_q == TICK_MAX);
    case (state_q)
      S_IDLE: begin
        if (host_start) state_d = S_READY;
      end
      S_READY: begin
        if (host_skip) begin
          code_d  = 2'b00;
          state_d = S_COMMIT;
        end else if (btn_edge != 4'd0) begin
          winner_d  = grant;
          code_d    = 2'b11;
          buzz_load = 1'b1;
          state_d   = S_COMMIT;
        end else if (host_start) begin
          time_d  = BUZZ_TIME_C;
          tick_d  = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (host_skip) begin
          code_d  = 2'b00;
          state_d = S_COMMIT;
        end else if (btn_edge != 4'd0) begin
          winner_d  = grant;
          time_d    = ANS_TIME_C;
          tick_d    = '0;
          buzz_load = 1'b1;
          state_d   = S_LOCKED;
        end else if (tick_wrap) begin
          tick_d = '0;
          time_d = time_q - 4'd1;
          if (time_q <= 4'd1) begin
            code_d    = 2'b00;
            buzz_load = 1'b1;
            state_d   = S_COMMIT;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (host_skip) begin
          code_d  = 2'b00;
          state_d = S_COMMIT;
        end else if (host_correct) begin
          code_d  = 2'b01;
          state_d = S_COMMIT;
        end else if (host_wrong) begin
          code_d  = 2'b10;
          state_d = S_COMMIT;
        end else if (tick_wrap) begin
          tick_d = '0;
          time_d = time_q - 4'd1;
          if (time_q <= 4'd1) begin
            code_d  = 2'b10;
            state_d = S_COMMIT;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_COMMIT: begin
        for (int p = 0; p < 4; p++)
          for (int q = 0; q < MAX_Q; q++)
            if (winner_q[p] && q == int'(play_q)) list_d[p][2*q +: 2] = code_q;
        play_d   = play_q + 4'd1;
        winner_d = 4'd0;
        code_d   = 2'b00;
        state_d  = (play_q + 4'd1 == MAX_Q_C) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_ARMED && state_d != S_LOCKED) begin
      time_d = 4'd0;
      tick_d = '0;
    end
  end

  // datapath registers, including the buzzer down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      play_q   <= 4'd0;
      winner_q <= 4'd0;
      time_q   <= 4'd0;
      tick_q   <= '0;
      code_q   <= 2'b00;
      buzz_q   <= '0;
      for (int p = 0; p < 4; p++) list_q[p] <= '0;
    end else begin
      play_q   <= play_d;
      winner_q <= winner_d;
      time_q   <= time_d;
      tick_q   <= tick_d;
      code_q   <= code_d;
      for (int p = 0; p < 4; p++) list_q[p] <= list_d[p];
      if (buzz_load)          buzz_q <= BUZZ_LOAD;
      else if (buzz_q != '0)  buzz_q <= buzz_q - 1'b1;
    end
  end

  assign state        = state_q;
  assign play_count   = play_q;
  assign winner       = winner_q;
  assign time_left    = time_q;
  assign buzzer       = (buzz_q != '0);
  assign player1_list = list_q[0];
  assign player2_list = list_q[1];
  assign player3_list = list_q[2];
  assign player4_list = list_q[3];

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Directed bench for quiz_round_arbiter with a 4-cycle second and a 6-cycle buzzer pulse.
module tb_quiz_round_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn_edge = 4'd0;
  logic        host_start = 1'b0, host_correct = 1'b0, host_wrong = 1'b0, host_skip = 1'b0;
  logic [3:0]  play_count, winner, time_left;
  logic [17:0] player1_list, player2_list, player3_list, player4_list;
  logic [2:0]  state;
  logic        buzzer;

  int n_checks = 0;
  int n_pass   = 0;

  quiz_round_arbiter #(
    .MAX_Q(9), .TICKS_PER_SEC(4), .BUZZ_TIME(5), .ANSWER_TIME(10), .BUZZ_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .btn_edge(btn_edge),
    .host_start(host_start), .host_correct(host_correct),
    .host_wrong(host_wrong), .host_skip(host_skip),
    .play_count(play_count),
    .player1_list(player1_list), .player2_list(player2_list),
    .player3_list(player3_list), .player4_list(player4_list),
    .winner(winner), .state(state), .time_left(time_left), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] b, input logic s, input logic c,
                       input logic w, input logic k);
    btn_edge = b; host_start = s; host_correct = c; host_wrong = w; host_skip = k;
    tick();
    btn_edge = 4'd0; host_start = 0; host_correct = 0; host_wrong = 0; host_skip = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_lists(input string tag, input logic [17:0] e1, input logic [17:0] e2,
                             input logic [17:0] e3, input logic [17:0] e4);
    check({tag, ".p1"}, 32'(player1_list), 32'(e1));
    check({tag, ".p2"}, 32'(player2_list), 32'(e2));
    check({tag, ".p3"}, 32'(player3_list), 32'(e3));
    check({tag, ".p4"}, 32'(player4_list), 32'(e4));
  endtask

  logic [17:0] exp_p2, exp_p4;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst.state", 32'(state), 0);
    check("rst.play", 32'(play_count), 0);
    check("rst.winner", 32'(winner), 0);
    check("rst.time", 32'(time_left), 0);
    check("rst.buzzer", 32'(buzzer), 0);
    check_lists("rst", 0, 0, 0, 0);

    // q1: player3 locks and answers correctly
    drive(4'b0000, 1, 0, 0, 0);
    check("q1.ready", 32'(state), 1);
    drive(4'b0000, 1, 0, 0, 0);
    check("q1.armed", 32'(state), 2);
    check("q1.buzz_time", 32'(time_left), 5);
    drive(4'b0100, 0, 0, 0, 0);
    check("q1.locked", 32'(state), 3);
    check("q1.winner", 32'(winner), 4'b0100);
    check("q1.ans_time", 32'(time_left), 10);
    check("q1.buzzer_on", 32'(buzzer), 1);
    drive(4'b0000, 0, 1, 0, 0);
    check("q1.commit", 32'(state), 4);
    tick();
    check("q1.idle", 32'(state), 0);
    check("q1.play", 32'(play_count), 1);
    check("q1.winner_clr", 32'(winner), 0);
    check_lists("q1", 18'h0, 18'h0, 18'h1, 18'h0);
    repeat (6) tick();
    check("q1.buzzer_off", 32'(buzzer), 0);

    // skip in IDLE is ignored
    drive(4'b0000, 0, 0, 0, 1);
    check("idle_skip.state", 32'(state), 0);

    // q2: player1 fouls during READY
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0001, 0, 0, 0, 0);
    check("q2.commit", 32'(state), 4);
    check("q2.winner", 32'(winner), 4'b0001);
    check("q2.buzzer", 32'(buzzer), 1);
    tick();
    check("q2.idle", 32'(state), 0);
    check("q2.play", 32'(play_count), 2);
    check_lists("q2", 18'hC, 18'h0, 18'h1, 18'h0);

    // q3: buzz window expires with no press
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    repeat (3) tick();
    check("q3.time_hold", 32'(time_left), 5);
    tick();
    check("q3.time_dec", 32'(time_left), 4);
    repeat (15) tick();
    check("q3.last_sec_state", 32'(state), 2);
    check("q3.last_sec_time", 32'(time_left), 1);
    tick();
    check("q3.expire_state", 32'(state), 4);
    check("q3.expire_time", 32'(time_left), 0);
    check("q3.expire_buzzer", 32'(buzzer), 1);
    tick();
    check("q3.play", 32'(play_count), 3);
    check_lists("q3", 18'hC, 18'h0, 18'h1, 18'h0);

    // q4: player2 locks, answer window expires
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0010, 0, 0, 0, 0);
    repeat (39) tick();
    check("q4.last_sec_state", 32'(state), 3);
    check("q4.last_sec_time", 32'(time_left), 1);
    tick();
    check("q4.expire_state", 32'(state), 4);
    tick();
    check("q4.play", 32'(play_count), 4);
    check_lists("q4", 18'hC, 18'h80, 18'h1, 18'h0);

    // q5: simultaneous presses 1010, then correct and wrong together
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b1010, 0, 0, 0, 0);
`ifdef ROUND_ROBIN_EN
    check("q5.winner", 32'(winner), 4'b1000);
    exp_p2 = 18'h80;
    exp_p4 = 18'h100;
`else
    check("q5.winner", 32'(winner), 4'b0010);
    exp_p2 = 18'h180;
    exp_p4 = 18'h0;
`endif
    drive(4'b0000, 0, 1, 1, 0);
    tick();
    check("q5.play", 32'(play_count), 5);
    check_lists("q5", 18'hC, exp_p2, 18'h1, exp_p4);

    // q6: skip together with correct in LOCKED
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0001, 0, 0, 0, 0);
    drive(4'b0000, 0, 1, 0, 1);
    check("q6.commit", 32'(state), 4);
    tick();
    check("q6.play", 32'(play_count), 6);
    check_lists("q6", 18'hC, exp_p2, 18'h1, exp_p4);

    // q7: press and start in the same READY cycle is a foul
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b1000, 1, 0, 0, 0);
    check("q7.commit", 32'(state), 4);
    check("q7.winner", 32'(winner), 4'b1000);
    tick();
    exp_p4 = exp_p4 | 18'h3000;
    check("q7.play", 32'(play_count), 7);
    check_lists("q7", 18'hC, exp_p2, 18'h1, exp_p4);

    // q8: press on the same cycle as buzz expiry wins
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    repeat (19) tick();
    check("q8.pre_time", 32'(time_left), 1);
    drive(4'b0100, 0, 0, 0, 0);
    check("q8.locked", 32'(state), 3);
    check("q8.winner", 32'(winner), 4'b0100);
    check("q8.time", 32'(time_left), 10);
    drive(4'b0000, 0, 0, 1, 0);
    tick();
    check("q8.play", 32'(play_count), 8);
    check_lists("q8", 18'hC, exp_p2, 18'h8001, exp_p4);

    // q9: skip in READY, game ends
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 1);
    tick();
    check("q9.done", 32'(state), 5);
    check("q9.play", 32'(play_count), 9);

    // DONE ignores all inputs
    drive(4'b1111, 1, 1, 0, 0);
    drive(4'b0000, 1, 0, 1, 1);
    check("done.state", 32'(state), 5);
    check("done.play", 32'(play_count), 9);
    check("done.winner", 32'(winner), 0);
    check_lists("done", 18'hC, exp_p2, 18'h8001, exp_p4);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.state", 32'(state), 0);
    check("rst2.play", 32'(play_count), 0);
    check_lists("rst2", 0, 0, 0, 0);

    // reset while LOCKED discards the question
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0001, 0, 0, 0, 0);
    check("rst3.pre_state", 32'(state), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst3.state", 32'(state), 0);
    check("rst3.play", 32'(play_count), 0);
    check("rst3.winner", 32'(winner), 0);
    check("rst3.time", 32'(time_left), 0);
    check("rst3.buzzer", 32'(buzzer), 0);
    check_lists("rst3", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
